// File: rtl/fios_operand_mem.sv
// ---------------------------------------------------------------------------
// fios_operand_mem
//   Operand and result storage around a FIOS Montgomery multiplier array.
//   The host loads X, Y, n (s blocks of 17 bits each, least significant
//   block first) and the single n_prime_0 block, then requests a run.
//   While running, the array pulls Y/n one block at a time, sees X through
//   a PE_NB-block window and pushes result blocks. Once the array flags the
//   last result, the stored result is streamed back out with valid/ready.
//
// Ports
//   clock_i, reset_n_i           clock, asynchronous active-low reset
//   load_valid_i/sel_i/data_i    host operand writes (IDLE only)
//   start_i                      run request
//   fios_start_o                 one-cycle start pulse to the array
//   X_o, Y_o, n_o, n_prime_0_o   operand views for the array
//   Y_fetch_i, n_fetch_i         advance the Y / n read pointer
//   shift_X_i                    advance the X window by PE_NB blocks
//   res_i, res_push_i, last_i    result block writes from the array
//   res_data_o/valid_o/ready_i   result read-out stream
//   busy_o, done_o, err_o        status (done pulses, err is sticky)
// ---------------------------------------------------------------------------
module fios_operand_mem #(
    parameter  int s     = 16,
    localparam int PE_NB = (2*s+5-1)/9+1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  load_valid_i,
    input  logic [1:0]            load_sel_i,
    input  logic [16:0]           load_data_i,
    input  logic                  start_i,
    output logic                  fios_start_o,
    output logic [PE_NB*17-1:0]   X_o,
    output logic [16:0]           n_prime_0_o,
    output logic [16:0]           Y_o,
    output logic [16:0]           n_o,
    input  logic                  Y_fetch_i,
    input  logic                  n_fetch_i,
    input  logic                  shift_X_i,
    input  logic [16:0]           res_i,
    input  logic                  res_push_i,
    input  logic                  last_i,
    output logic [16:0]           res_data_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int AW   = (s > 1) ? $clog2(s) : 1;
    localparam int CW   = $clog2(s + 1);
    // First multiple of PE_NB at or above s: the window parks here (all zeros).
    localparam int XMAX = ((s + PE_NB - 1) / PE_NB) * PE_NB;
    localparam int XW   = $clog2(XMAX + PE_NB + 1);

    typedef enum logic [1:0] {IDLE, RUN, READ} state_t;

    state_t          state_q, state_d;
    logic            run_en_q;
    logic [AW-1:0]   x_wr_q, x_wr_d, y_wr_q, y_wr_d, n_wr_q, n_wr_d;
    logic [3:0]      loaded_q, loaded_d;          // {n_prime_0, n, Y, X}
    logic [AW-1:0]   y_ptr_q, y_ptr_d, n_ptr_q, n_ptr_d;
    logic [XW-1:0]   x_base_q, x_base_d;
    logic [CW-1:0]   r_idx_q, r_idx_d, rd_idx_q, rd_idx_d;
    logic            fios_start_q, fios_start_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            x_we, y_we, n_we, np_we, r_we;

    logic [16:0]     x_mem [s];
    logic [16:0]     y_mem [s];
    logic [16:0]     n_mem [s];
    logic [16:0]     r_mem [s];
    logic [16:0]     np0_q;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v);
        return (v == AW'(s - 1)) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        x_wr_d       = x_wr_q;
        y_wr_d       = y_wr_q;
        n_wr_d       = n_wr_q;
        loaded_d     = loaded_q;
        y_ptr_d      = y_ptr_q;
        n_ptr_d      = n_ptr_q;
        x_base_d     = x_base_q;
        r_idx_d      = r_idx_q;
        rd_idx_d     = rd_idx_q;
        fios_start_d = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        x_we         = 1'b0;
        y_we         = 1'b0;
        n_we         = 1'b0;
        np_we        = 1'b0;
        r_we         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_valid_i) begin
                    unique case (load_sel_i)
                        2'd0: begin
                            x_we   = 1'b1;
                            x_wr_d = wrap_inc(x_wr_q);
                            if (x_wr_q == AW'(s - 1)) loaded_d[0] = 1'b1;
                        end
                        2'd1: begin
                            y_we   = 1'b1;
                            y_wr_d = wrap_inc(y_wr_q);
                            if (y_wr_q == AW'(s - 1)) loaded_d[1] = 1'b1;
                        end
                        2'd2: begin
                            n_we   = 1'b1;
                            n_wr_d = wrap_inc(n_wr_q);
                            if (n_wr_q == AW'(s - 1)) loaded_d[2] = 1'b1;
                        end
                        2'd3: begin
                            np_we       = 1'b1;
                            loaded_d[3] = 1'b1;
                        end
                    endcase
                end
                if (start_i) begin
                    if (&loaded_q) begin
                        state_d      = RUN;
                        fios_start_d = 1'b1;
                        y_ptr_d      = '0;
                        n_ptr_d      = '0;
                        x_base_d     = '0;
                        r_idx_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (load_valid_i) err_d = 1'b1;
                if (Y_fetch_i) y_ptr_d = wrap_inc(y_ptr_q);
                if (n_fetch_i) n_ptr_d = wrap_inc(n_ptr_q);
                if (shift_X_i && (x_base_q < XW'(XMAX))) x_base_d = x_base_q + XW'(PE_NB);
                if (res_push_i) begin
                    if (r_idx_q == CW'(s)) begin
                        err_d = 1'b1;
                    end else begin
                        r_we    = 1'b1;
                        r_idx_d = r_idx_q + 1'b1;
                    end
                end
                if (last_i) begin
                    state_d  = READ;
                    rd_idx_d = '0;
                end
            end

            READ: begin
                if (load_valid_i) err_d = 1'b1;
                if (r_idx_q == '0) begin
                    // Nothing was pushed: finish without presenting any data.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (res_ready_i) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == r_idx_q - 1'b1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset release is registered once so the first state update lands on
    // the second rising edge after deassertion.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) run_en_q <= 1'b0;
        else            run_en_q <= 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            x_wr_q       <= '0;
            y_wr_q       <= '0;
            n_wr_q       <= '0;
            loaded_q     <= '0;
            y_ptr_q      <= '0;
            n_ptr_q      <= '0;
            x_base_q     <= '0;
            r_idx_q      <= '0;
            rd_idx_q     <= '0;
            fios_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (run_en_q) begin
            state_q      <= state_d;
            x_wr_q       <= x_wr_d;
            y_wr_q       <= y_wr_d;
            n_wr_q       <= n_wr_d;
            loaded_q     <= loaded_d;
            y_ptr_q      <= y_ptr_d;
            n_ptr_q      <= n_ptr_d;
            x_base_q     <= x_base_d;
            r_idx_q      <= r_idx_d;
            rd_idx_q     <= rd_idx_d;
            fios_start_q <= fios_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Storage arrays: no reset, contents are defined only once loaded.
    always_ff @(posedge clock_i) begin
        if (run_en_q) begin
            if (x_we)  x_mem[x_wr_q]             <= load_data_i;
            if (y_we)  y_mem[y_wr_q]             <= load_data_i;
            if (n_we)  n_mem[n_wr_q]             <= load_data_i;
            if (np_we) np0_q                     <= load_data_i;
            if (r_we)  r_mem[r_idx_q[AW-1:0]]    <= res_i;
        end
    end

    // X window: blocks past the top of the operand read as zero.
    for (genvar gi = 0; gi < PE_NB; gi++) begin : g_xwin
        logic [XW-1:0] idx;
        assign idx = x_base_q + XW'(gi);
        assign X_o[gi*17 +: 17] = (idx < XW'(s)) ? x_mem[idx[AW-1:0]] : 17'd0;
    end

    assign Y_o          = y_mem[y_ptr_q];
    assign n_o          = n_mem[n_ptr_q];
    assign n_prime_0_o  = np0_q;
    assign res_data_o   = r_mem[rd_idx_q[AW-1:0]];
    assign res_valid_o  = (state_q == READ) && (r_idx_q != '0);
    assign fios_start_o = fios_start_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fios_operand_mem.sv
// ---------------------------------------------------------------------------
// tb_fios_operand_mem
//   Self-checking bench for fios_operand_mem (s = 16, PE_NB = 5).
//   Window/fetch behaviour is checked from a vector table; the result
//   stream is checked against a scoreboard queue filled as blocks are pushed.
// ---------------------------------------------------------------------------
module tb_fios_operand_mem;

    localparam int S  = 16;
    localparam int PE = 5;
    localparam int XWD = PE * 17;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load_valid = 1'b0;
    logic [1:0]      load_sel = '0;
    logic [16:0]     load_data = '0;
    logic            start = 1'b0;
    logic            fios_start;
    logic [XWD-1:0]  X_o;
    logic [16:0]     np0, Y_o, n_o, res_i = '0, res_data;
    logic            y_fetch = 1'b0, n_fetch = 1'b0, shift_x = 1'b0;
    logic            res_push = 1'b0, last = 1'b0, res_valid, res_ready = 1'b0;
    logic            busy, done, err;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [16:0] sb_q[$];

    typedef struct {
        logic            do_shift;
        logic            do_yf;
        logic [XWD-1:0]  exp_x;
        logic [16:0]     exp_y;
    } vec_t;
    vec_t vecs [22];

    fios_operand_mem #(.s(S)) dut (
        .clock_i(clk), .reset_n_i(reset_n),
        .load_valid_i(load_valid), .load_sel_i(load_sel), .load_data_i(load_data),
        .start_i(start), .fios_start_o(fios_start),
        .X_o(X_o), .n_prime_0_o(np0), .Y_o(Y_o), .n_o(n_o),
        .Y_fetch_i(y_fetch), .n_fetch_i(n_fetch), .shift_X_i(shift_x),
        .res_i(res_i), .res_push_i(res_push), .last_i(last),
        .res_data_o(res_data), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [XWD-1:0] act, input logic [XWD-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("[%0t] %s = %0h ok", $time, name, act);
        end
    endtask

    function automatic logic [XWD-1:0] win(input int a0, a1, a2, a3, a4);
        return {17'(a4), 17'(a3), 17'(a2), 17'(a1), 17'(a0)};
    endfunction

    task automatic load_op(input logic [1:0] sel, input int cnt, input int base);
        for (int i = 0; i < cnt; i++) begin
            load_valid = 1'b1;
            load_sel   = sel;
            load_data  = 17'(base + i);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Push cnt blocks; only the first S fit, so only those are expected back.
    task automatic push_seq(input int cnt, input int base, input bit last_on_final);
        for (int i = 0; i < cnt; i++) begin
            res_push = 1'b1;
            res_i    = 17'(base + i);
            last     = last_on_final && (i == cnt - 1);
            if (i < S) sb_q.push_back(17'(base + i));
            tick();
            if (i == S - 1) check("err_before_overflow", {84'd0, err}, 85'd0);
            if (i == S)     check("err_after_overflow",  {84'd0, err}, 85'd1);
        end
        res_push = 1'b0;
        last     = 1'b0;
    endtask

    // Compare transfers against the scoreboard until cnt blocks moved.
    task automatic drain(input int cnt, input int limit);
        int got = 0;
        int cyc = 0;
        logic [16:0] exp;
        while (got < cnt && cyc < limit) begin
            if (res_valid && res_ready) begin
                exp = sb_q.pop_front();
                check("res_data", {68'd0, res_data}, {68'd0, exp});
                got++;
            end
            tick();
            cyc++;
        end
        if (got < cnt) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d blocks transferred, required %0d", got, cnt);
        end
    endtask

    initial begin
        int dc0;

        for (int i = 0; i < 22; i++) begin
            vecs[i].do_shift = (i < 5);
            vecs[i].do_yf    = (i >= 5);
            vecs[i].exp_x    = '0;
            vecs[i].exp_y    = (i < 5) ? 17'h100 : 17'(32'h100 + ((i - 4) % 16));
        end
        vecs[0].exp_x = win(6, 7, 8, 9, 10);
        vecs[1].exp_x = win(11, 12, 13, 14, 15);
        vecs[2].exp_x = win(16, 0, 0, 0, 0);

        // Reset state
        tick(); tick();
        check("rst_fios_start", {84'd0, fios_start}, 85'd0);
        check("rst_res_valid",  {84'd0, res_valid},  85'd0);
        check("rst_busy",       {84'd0, busy},       85'd0);
        check("rst_done",       {84'd0, done},       85'd0);
        check("rst_err",        {84'd0, err},        85'd0);
        reset_n = 1'b1;
        tick(); tick();

        // Load operands and start
        load_op(2'd0, S, 1);
        load_op(2'd1, S, 'h100);
        load_op(2'd2, S, 'h200);
        load_op(2'd3, 1, 'h1ABCD);
        check("n_prime_0", {68'd0, np0}, {68'd0, 17'h1ABCD});
        check("idle_busy", {84'd0, busy}, 85'd0);
        do_start();
        check("start_pulse", {84'd0, fios_start}, 85'd1);
        check("run_busy",    {84'd0, busy},       85'd1);
        check("x_win0",      X_o, win(1, 2, 3, 4, 5));
        check("y_blk0",      {68'd0, Y_o}, {68'd0, 17'h100});
        check("n_blk0",      {68'd0, n_o}, {68'd0, 17'h200});
        tick();
        check("start_pulse_end", {84'd0, fios_start}, 85'd0);

        // Table: five X shifts then seventeen Y fetches (one with an n fetch)
        for (int i = 0; i < 22; i++) begin
            shift_x = vecs[i].do_shift;
            y_fetch = vecs[i].do_yf;
            n_fetch = (i == 5);
            tick();
            shift_x = 1'b0;
            y_fetch = 1'b0;
            n_fetch = 1'b0;
            check($sformatf("x_win[%0d]", i), X_o, vecs[i].exp_x);
            check($sformatf("y_blk[%0d]", i), {68'd0, Y_o}, {68'd0, vecs[i].exp_y});
        end
        check("n_blk1", {68'd0, n_o}, {68'd0, 17'h201});

        // Results with back-pressure, then full read-out
        push_seq(S, 0, 1'b1);
        dc0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {84'd0, res_valid}, 85'd1);
            check("stall_data",  {68'd0, res_data},  85'd0);
            tick();
        end
        res_ready = 1'b1;
        drain(S, 40);
        res_ready = 1'b0;
        check("done_pulse", {84'd0, done}, 85'd1);
        check("done_busy",  {84'd0, busy}, 85'd0);
        tick();
        check("done_end",   {84'd0, done}, 85'd0);
        check("done_count", 85'(done_cnt - dc0), 85'd1);
        check("err_clean",  {84'd0, err}, 85'd0);

        // Rerun with retained operands: overflow push, then abort mid-read
        do_start();
        check("rerun_pulse", {84'd0, fios_start}, 85'd1);
        check("rerun_x_win", X_o, win(1, 2, 3, 4, 5));
        push_seq(S + 1, 'h20, 1'b0);
        last = 1'b1;
        tick();
        last = 1'b0;
        res_ready = 1'b1;
        drain(2, 10);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", {84'd0, res_valid},  85'd0);
        check("abort_busy",  {84'd0, busy},       85'd0);
        check("abort_err",   {84'd0, err},        85'd0);
        dc0 = done_cnt;
        res_ready = 1'b0;
        sb_q.delete();
        tick(); tick();
        reset_n = 1'b1;
        start = 1'b1;
        tick();
        check("sync_first_edge_err", {84'd0, err}, 85'd0);
        tick();
        start = 1'b0;
        check("reload_needed_pulse", {84'd0, fios_start}, 85'd0);
        check("reload_needed_err",   {84'd0, err},        85'd1);
        check("abort_no_done", 85'(done_cnt - dc0), 85'd0);

        // Start with n missing, then complete and run an empty result
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        load_op(2'd0, S, 1);
        load_op(2'd1, S, 'h100);
        load_op(2'd3, 1, 'h1ABCD);
        do_start();
        check("n_missing_pulse", {84'd0, fios_start}, 85'd0);
        check("n_missing_err",   {84'd0, err},        85'd1);
        load_op(2'd2, S, 'h200);
        do_start();
        check("n_loaded_pulse",  {84'd0, fios_start}, 85'd1);
        last = 1'b1;
        tick();
        last = 1'b0;
        check("empty_busy",  {84'd0, busy},      85'd1);
        check("empty_valid", {84'd0, res_valid}, 85'd0);
        tick();
        check("empty_done",  {84'd0, done}, 85'd1);
        check("empty_idle",  {84'd0, busy}, 85'd0);
        tick();
        check("empty_done_end", {84'd0, done}, 85'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
